// File: rtl/alu_issue_queue_pkg.sv
// Shared types and constants for the ALU issue queue slice.
// Feature macro: ALU_ISQ_BYPASS_EN (same-cycle wakeup bypass into select/issue).
package alu_issue_queue_pkg;

    localparam int unsigned ALU_ISQ_DEPTH = 4;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;
    typedef logic [3:0]  regtag_t;
    typedef logic [4:0]  regaddr_t;
    typedef logic [5:0]  sinst_t;

    localparam regtag_t UNLOCKED = '0;

    typedef struct packed {
        sinst_t   op;
        addr_t    pc;
        regtag_t  tagx;
        regtag_t  tagy;
        regtag_t  tagw;
        word_t    datax;
        word_t    datay;
        regaddr_t target;
    } isq_entry_t;

    // A broadcast only matches real tags; UNLOCKED never wakes anything.
    function automatic logic tag_hit(regtag_t tag, logic wb_en, regtag_t wb_tag);
        return wb_en && (wb_tag != UNLOCKED) && (tag == wb_tag);
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, writeback-broadcast and issue bundle of the ALU issue queue.
// Feature macro: none (ALU_ISQ_BYPASS_EN only affects the queue internals).
interface alu_issue_queue_if #(parameter int unsigned IDX_W = 2);
    import alu_issue_queue_pkg::*;

    logic     disp_valid;
    logic     disp_ready;
    sinst_t   disp_op;
    addr_t    disp_pc;
    regtag_t  disp_tagx;
    regtag_t  disp_tagy;
    regtag_t  disp_tagw;
    word_t    disp_datax;
    word_t    disp_datay;
    regaddr_t disp_target;

    logic     wb_en;
    regtag_t  wb_tag;
    word_t    wb_data;

    logic     alu_busy_out;
    sinst_t   alu_op;
    addr_t    alu_pc;
    regtag_t  alu_tagx;
    regtag_t  alu_tagy;
    regtag_t  alu_tagw;
    word_t    alu_datax;
    word_t    alu_datay;
    regaddr_t alu_target;

    logic [IDX_W:0] count;

    modport slave (
        input  disp_valid, disp_op, disp_pc, disp_tagx, disp_tagy, disp_tagw,
               disp_datax, disp_datay, disp_target, wb_en, wb_tag, wb_data,
        output disp_ready, alu_busy_out, alu_op, alu_pc, alu_tagx, alu_tagy,
               alu_tagw, alu_datax, alu_datay, alu_target, count
    );

    modport master (
        output disp_valid, disp_op, disp_pc, disp_tagx, disp_tagy, disp_tagw,
               disp_datax, disp_datay, disp_target, wb_en, wb_tag, wb_data,
        input  disp_ready, alu_busy_out, alu_op, alu_pc, alu_tagx, alu_tagy,
               alu_tagw, alu_datax, alu_datay, alu_target, count
    );

endinterface

// File: rtl/alu_isq_select.sv
// Combinational oldest-ready picker: lowest rank among valid & ready entries.
// Feature macro: none.
module alu_isq_select #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [DEPTH-1:0]       valid,
    input  logic [DEPTH-1:0]       ready,
    input  logic [DEPTH*IDX_W-1:0] rank,
    output logic                   hit,
    output logic [IDX_W-1:0]       idx
);

    logic [IDX_W-1:0] best;

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        best = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && ready[i] && (!hit || (rank[i*IDX_W +: IDX_W] < best))) begin
                hit  = 1'b1;
                idx  = IDX_W'(i);
                best = rank[i*IDX_W +: IDX_W];
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Reservation station for the integer ALU: wakeup, oldest-ready issue, flush.
// Feature macro: ALU_ISQ_BYPASS_EN lets a same-cycle broadcast make an entry issuable.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = ALU_ISQ_DEPTH,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    alu_issue_queue_if.slave bus
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

    isq_entry_t             ent   [DEPTH];
    logic [IDX_W-1:0]       rank  [DEPTH];
    logic [DEPTH-1:0]       valid;
    logic [IDX_W:0]         cnt;

    logic [DEPTH-1:0]       wx, wy, ww, ready;
    logic [DEPTH*IDX_W-1:0] rank_flat;
    logic                   sel_hit;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       sel_rank;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;
    logic                   accept;
    logic                   issue;
    isq_entry_t             disp_entry;
    isq_entry_t             sel_entry;

    assign bus.disp_ready = (cnt < FULL_CNT);
    assign bus.count      = cnt;
    assign accept         = bus.disp_valid && bus.disp_ready;
    assign issue          = sel_hit;
    assign sel_rank       = rank[sel_idx];

    always_comb begin
        wx        = '0;
        wy        = '0;
        ww        = '0;
        ready     = '0;
        rank_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wx[i] = valid[i] && tag_hit(ent[i].tagx, bus.wb_en, bus.wb_tag);
            wy[i] = valid[i] && tag_hit(ent[i].tagy, bus.wb_en, bus.wb_tag);
            ww[i] = valid[i] && tag_hit(ent[i].tagw, bus.wb_en, bus.wb_tag);
`ifdef ALU_ISQ_BYPASS_EN
            ready[i] = (ent[i].tagx == UNLOCKED || wx[i]) &&
                       (ent[i].tagy == UNLOCKED || wy[i]) &&
                       (ent[i].tagw == UNLOCKED || ww[i]);
`else
            ready[i] = (ent[i].tagx == UNLOCKED) &&
                       (ent[i].tagy == UNLOCKED) &&
                       (ent[i].tagw == UNLOCKED);
`endif
            rank_flat[i*IDX_W +: IDX_W] = rank[i];
        end
    end

    alu_isq_select #(
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) u_select (
        .valid(valid),
        .ready(ready),
        .rank (rank_flat),
        .hit  (sel_hit),
        .idx  (sel_idx)
    );

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Incoming operands see the same-cycle broadcast so a wakeup is never missed.
    always_comb begin
        disp_entry = '{op: bus.disp_op, pc: bus.disp_pc,
                       tagx: bus.disp_tagx, tagy: bus.disp_tagy, tagw: bus.disp_tagw,
                       datax: bus.disp_datax, datay: bus.disp_datay,
                       target: bus.disp_target};
        if (tag_hit(bus.disp_tagx, bus.wb_en, bus.wb_tag)) begin
            disp_entry.tagx  = UNLOCKED;
            disp_entry.datax = bus.wb_data;
        end
        if (tag_hit(bus.disp_tagy, bus.wb_en, bus.wb_tag)) begin
            disp_entry.tagy  = UNLOCKED;
            disp_entry.datay = bus.wb_data;
        end
        if (tag_hit(bus.disp_tagw, bus.wb_en, bus.wb_tag)) begin
            disp_entry.tagw = UNLOCKED;
        end
    end

    always_comb begin
        sel_entry = ent[sel_idx];
`ifdef ALU_ISQ_BYPASS_EN
        if (wx[sel_idx]) sel_entry.datax = bus.wb_data;
        if (wy[sel_idx]) sel_entry.datay = bus.wb_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid            <= '0;
            cnt              <= '0;
            bus.alu_busy_out <= 1'b0;
            bus.alu_op       <= '0;
            bus.alu_pc       <= '0;
            bus.alu_tagx     <= UNLOCKED;
            bus.alu_tagy     <= UNLOCKED;
            bus.alu_tagw     <= UNLOCKED;
            bus.alu_datax    <= '0;
            bus.alu_datay    <= '0;
            bus.alu_target   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent[i]  <= '0;
                rank[i] <= '0;
            end
        end else if (rdy) begin
            if (flush) begin
                valid            <= '0;
                cnt              <= '0;
                bus.alu_busy_out <= 1'b0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (wx[i]) begin
                        ent[i].tagx  <= UNLOCKED;
                        ent[i].datax <= bus.wb_data;
                    end
                    if (wy[i]) begin
                        ent[i].tagy  <= UNLOCKED;
                        ent[i].datay <= bus.wb_data;
                    end
                    if (ww[i]) ent[i].tagw <= UNLOCKED;
                    // Younger entries close the gap left by the issued one.
                    if (issue && (IDX_W'(i) == sel_idx)) begin
                        valid[i] <= 1'b0;
                    end else if (issue && valid[i] && (rank[i] > sel_rank)) begin
                        rank[i] <= rank[i] - IDX_W'(1);
                    end
                end
                if (accept) begin
                    valid[free_idx] <= 1'b1;
                    ent[free_idx]   <= disp_entry;
                    rank[free_idx]  <= cnt[IDX_W-1:0] - IDX_W'(issue);
                end
                cnt <= cnt + (IDX_W+1)'(accept) - (IDX_W+1)'(issue);
                if (issue) begin
                    bus.alu_busy_out <= 1'b1;
                    bus.alu_op       <= sel_entry.op;
                    bus.alu_pc       <= sel_entry.pc;
                    bus.alu_tagx     <= UNLOCKED;
                    bus.alu_tagy     <= UNLOCKED;
                    bus.alu_tagw     <= UNLOCKED;
                    bus.alu_datax    <= sel_entry.datax;
                    bus.alu_datay    <= sel_entry.datay;
                    bus.alu_target   <= sel_entry.target;
                end else begin
                    bus.alu_busy_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed table, multi-cycle sequences, random vs. model.
// Feature macro: ALU_ISQ_BYPASS_EN selects the matching reference timing.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
`ifdef ALU_ISQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, rdy, flush;
    always #5 clk = ~clk;

    alu_issue_queue_if #(.IDX_W(2)) bus ();

    alu_issue_queue #(.DEPTH(DEPTH), .IDX_W(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rdy  (rdy),
        .flush(flush),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: age-ordered list, oldest at the front.
    typedef struct {
        sinst_t op; addr_t pc; regtag_t tx, ty, tw; word_t dx, dy; regaddr_t tgt;
    } ment_t;
    ment_t    mq[$];
    logic     m_busy;
    ment_t    m_out;

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0;
        m_out  = '{op: '0, pc: '0, tx: UNLOCKED, ty: UNLOCKED, tw: UNLOCKED,
                   dx: '0, dy: '0, tgt: '0};
    endtask

    function automatic logic hit(regtag_t t);
        return bus.wb_en && bus.wb_tag != UNLOCKED && t == bus.wb_tag;
    endfunction

    function automatic ment_t wake(ment_t e);
        ment_t r = e;
        if (hit(e.tx)) begin r.tx = UNLOCKED; r.dx = bus.wb_data; end
        if (hit(e.ty)) begin r.ty = UNLOCKED; r.dy = bus.wb_data; end
        if (hit(e.tw)) r.tw = UNLOCKED;
        return r;
    endfunction

    function automatic logic is_ready(ment_t e);
        return (e.tx == UNLOCKED || (BYP && hit(e.tx))) &&
               (e.ty == UNLOCKED || (BYP && hit(e.ty))) &&
               (e.tw == UNLOCKED || (BYP && hit(e.tw)));
    endfunction

    task automatic model_step();
        int    sel;
        int    n0;
        ment_t e;
        if (!rdy) return;
        if (flush) begin
            mq.delete();
            m_busy = 1'b0;
            return;
        end
        n0  = mq.size();
        sel = -1;
        for (int i = 0; i < mq.size(); i++)
            if (sel < 0 && is_ready(mq[i])) sel = i;
        if (sel >= 0) begin
            e = mq[sel];
            if (BYP) e = wake(e);
            m_out = e;
            m_out.tx = UNLOCKED; m_out.ty = UNLOCKED; m_out.tw = UNLOCKED;
            m_busy = 1'b1;
            mq.delete(sel);
        end else begin
            m_busy = 1'b0;
        end
        for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
        if (bus.disp_valid && n0 < DEPTH) begin
            e = '{op: bus.disp_op, pc: bus.disp_pc, tx: bus.disp_tagx, ty: bus.disp_tagy,
                  tw: bus.disp_tagw, dx: bus.disp_datax, dy: bus.disp_datay,
                  tgt: bus.disp_target};
            mq.push_back(wake(e));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_model(string tag);
        chk({tag, "_busy"},   32'(bus.alu_busy_out), 32'(m_busy));
        chk({tag, "_count"},  32'(bus.count),        32'(mq.size()));
        chk({tag, "_ready"},  32'(bus.disp_ready),   32'(mq.size() < DEPTH));
        chk({tag, "_op"},     32'(bus.alu_op),       32'(m_out.op));
        chk({tag, "_pc"},     bus.alu_pc,            m_out.pc);
        chk({tag, "_tags"},   32'({bus.alu_tagx, bus.alu_tagy, bus.alu_tagw}),
                              32'({m_out.tx, m_out.ty, m_out.tw}));
        chk({tag, "_datax"},  bus.alu_datax,         m_out.dx);
        chk({tag, "_datay"},  bus.alu_datay,         m_out.dy);
        chk({tag, "_target"}, 32'(bus.alu_target),   32'(m_out.tgt));
    endtask

    task automatic drive_idle();
        rdy = 1'b1; flush = 1'b0;
        bus.disp_valid = 1'b0; bus.disp_op = '0; bus.disp_pc = '0;
        bus.disp_tagx = UNLOCKED; bus.disp_tagy = UNLOCKED; bus.disp_tagw = UNLOCKED;
        bus.disp_datax = '0; bus.disp_datay = '0; bus.disp_target = '0;
        bus.wb_en = 1'b0; bus.wb_tag = UNLOCKED; bus.wb_data = '0;
    endtask

    task automatic drive_disp(regtag_t tx, regtag_t ty, regtag_t tw, word_t dx, word_t dy,
                              sinst_t op, addr_t pc, regaddr_t tgt);
        bus.disp_valid = 1'b1; bus.disp_op = op; bus.disp_pc = pc;
        bus.disp_tagx = tx; bus.disp_tagy = ty; bus.disp_tagw = tw;
        bus.disp_datax = dx; bus.disp_datay = dy; bus.disp_target = tgt;
    endtask

    typedef struct {
        logic rdy, fl, dv; regtag_t tx, ty; word_t dx, dy;
        logic wbe; regtag_t wbt; word_t wbd;
        logic e_busy; int unsigned e_cnt; word_t e_dx, e_dy;
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic dv, regtag_t tx, regtag_t ty,
                                word_t dx, word_t dy, logic wbe, regtag_t wbt, word_t wbd,
                                logic eb, int unsigned ec, word_t edx, word_t edy);
        vec_t v;
        v.rdy = r; v.fl = f; v.dv = dv; v.tx = tx; v.ty = ty; v.dx = dx; v.dy = dy;
        v.wbe = wbe; v.wbt = wbt; v.wbd = wbd;
        v.e_busy = eb; v.e_cnt = ec; v.e_dx = edx; v.e_dy = edy;
        return v;
    endfunction

    vec_t tbl[21];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;

        // Directed table: basic issue, out-of-order wakeup, dispatch-time capture, flush, stall.
        tbl[0]  = mk(1,0,1, 0,0, 5,7,       0,0,0,     0,1, 0,0);
        tbl[1]  = mk(1,0,0, 0,0, 0,0,       0,0,0,     1,0, 5,7);
        tbl[2]  = mk(1,0,0, 0,0, 0,0,       0,0,0,     0,0, 0,0);
        tbl[3]  = mk(1,0,1, 3,0, 0,1,       0,0,0,     0,1, 0,0);
        tbl[4]  = mk(1,0,1, 0,0, 20,21,     0,0,0,     0,2, 0,0);
        tbl[5]  = mk(1,0,0, 0,0, 0,0,       0,0,0,     1,1, 20,21);
        if (BYP) begin
            tbl[6] = mk(1,0,0, 0,0, 0,0,    1,3,9,     1,0, 9,1);
            tbl[7] = mk(1,0,0, 0,0, 0,0,    0,0,0,     0,0, 0,0);
        end else begin
            tbl[6] = mk(1,0,0, 0,0, 0,0,    1,3,9,     0,1, 0,0);
            tbl[7] = mk(1,0,0, 0,0, 0,0,    0,0,0,     1,0, 9,1);
        end
        tbl[8]  = mk(1,0,1, 0,6, 1,0,       1,6,32'h55, 0,1, 0,0);
        tbl[9]  = mk(1,0,0, 0,0, 0,0,       0,0,0,     1,0, 1,32'h55);
        tbl[10] = mk(1,0,1, 5,0, 0,1,       0,0,0,     0,1, 0,0);
        tbl[11] = mk(1,0,1, 5,0, 0,1,       0,0,0,     0,2, 0,0);
        tbl[12] = mk(1,0,1, 5,0, 0,1,       0,0,0,     0,3, 0,0);
        tbl[13] = mk(1,1,1, 0,0, 3,3,       0,0,0,     0,0, 0,0);
        tbl[14] = mk(1,0,0, 0,0, 0,0,       1,5,1,     0,0, 0,0);
        tbl[15] = mk(1,0,0, 0,0, 0,0,       0,0,0,     0,0, 0,0);
        tbl[16] = mk(1,0,1, 0,0, 40,41,     0,0,0,     0,1, 0,0);
        tbl[17] = mk(0,0,1, 0,0, 50,50,     0,0,0,     0,1, 0,0);
        tbl[18] = mk(0,0,1, 0,0, 50,50,     0,0,0,     0,1, 0,0);
        tbl[19] = mk(0,0,1, 0,0, 50,50,     0,0,0,     0,1, 0,0);
        tbl[20] = mk(1,0,0, 0,0, 0,0,       0,0,0,     1,0, 40,41);

        drive_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(bus.alu_busy_out), 32'd0);
        chk("rst_count", 32'(bus.count),        32'd0);
        chk("rst_ready", 32'(bus.disp_ready),   32'd1);
        chk("rst_tags",  32'({bus.alu_tagx, bus.alu_tagy, bus.alu_tagw}), 32'(UNLOCKED));
        chk("rst_data",  bus.alu_datax | bus.alu_datay | bus.alu_pc, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive_idle();
            rdy = tbl[i].rdy; flush = tbl[i].fl;
            if (tbl[i].dv)
                drive_disp(tbl[i].tx, tbl[i].ty, UNLOCKED, tbl[i].dx, tbl[i].dy,
                           6'h01, 32'(i * 4), 5'(i));
            bus.wb_en = tbl[i].wbe; bus.wb_tag = tbl[i].wbt; bus.wb_data = tbl[i].wbd;
            step();
            chk($sformatf("t%0d_busy", i),  32'(bus.alu_busy_out), 32'(tbl[i].e_busy));
            chk($sformatf("t%0d_count", i), 32'(bus.count),        tbl[i].e_cnt);
            chk($sformatf("t%0d_ready", i), 32'(bus.disp_ready),   32'(tbl[i].e_cnt < DEPTH));
            if (tbl[i].e_busy) begin
                chk($sformatf("t%0d_datax", i), bus.alu_datax, tbl[i].e_dx);
                chk($sformatf("t%0d_datay", i), bus.alu_datay, tbl[i].e_dy);
                chk($sformatf("t%0d_tagx", i),  32'(bus.alu_tagx), 32'(UNLOCKED));
            end
        end

        // Fill to capacity behind one tag, reject the overflow, then drain in age order.
        drive_idle();
        for (int k = 0; k < 4; k++) begin
            drive_disp(4'd2, UNLOCKED, UNLOCKED, 32'd0, 32'(10 + k), 6'h02, 32'h100 + 32'(k), 5'(k));
            step();
        end
        chk("fill_count", 32'(bus.count),      32'd4);
        chk("fill_ready", 32'(bus.disp_ready), 32'd0);
        drive_disp(UNLOCKED, UNLOCKED, UNLOCKED, 32'd99, 32'd99, 6'h03, 32'h200, 5'd9);
        step();
        chk("over_count", 32'(bus.count),        32'd4);
        chk("over_busy",  32'(bus.alu_busy_out), 32'd0);
        drive_idle();
        bus.wb_en = 1'b1; bus.wb_tag = 4'd2; bus.wb_data = 32'h77;
        got = 0;
        for (int c = 0; c < 10 && got < 4; c++) begin
            step();
            drive_idle();
            if (bus.alu_busy_out) begin
                chk($sformatf("drain%0d_datay", got), bus.alu_datay, 32'(10 + got));
                chk($sformatf("drain%0d_datax", got), bus.alu_datax, 32'h77);
                got++;
            end
            check_model("drain");
        end
        chk("drain_issued", 32'(got), 32'd4);
        step();
        chk("drain_count", 32'(bus.count), 32'd0);

        // Reset asserted mid-cycle drops queued work without issuing it.
        drive_disp(UNLOCKED, UNLOCKED, UNLOCKED, 32'd1, 32'd2, 6'h04, 32'h300, 5'd1);
        step();
        drive_disp(4'd7, UNLOCKED, UNLOCKED, 32'd1, 32'd2, 6'h04, 32'h304, 5'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_count", 32'(bus.count),        32'd0);
        chk("mrst_busy",  32'(bus.alu_busy_out), 32'd0);
        model_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        step();
        check_model("post_rst");

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            rdy   = ($urandom % 8) != 0;
            flush = ($urandom % 32) == 0;
            if ($urandom % 3 != 0)
                drive_disp(($urandom % 2) ? UNLOCKED : regtag_t'($urandom_range(1, 3)),
                           ($urandom % 2) ? UNLOCKED : regtag_t'($urandom_range(1, 3)),
                           ($urandom % 4) ? UNLOCKED : regtag_t'($urandom_range(1, 3)),
                           $urandom, $urandom, sinst_t'($urandom), $urandom,
                           regaddr_t'($urandom));
            bus.wb_en   = $urandom % 2;
            bus.wb_tag  = regtag_t'($urandom_range(0, 3));
            bus.wb_data = $urandom;
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
